// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the data-memory responder.
//   dmem_state_t        - responder FSM states (IDLE, WAIT, RESP)
//   DMEM_DEPTH_DEFAULT  - default number of words
//   DMEM_WAIT_DEFAULT   - default number of wait states
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_DEPTH_DEFAULT = 64;
    localparam int DMEM_WAIT_DEFAULT  = 2;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous-write, asynchronous-read word storage.
// Optional macro DMEM_PARITY_EN adds one even-parity bit per word.
// Ports:
//   clk       - clock, writes on rising edge
//   we        - write enable
//   addr      - word index (shared by read and write)
//   wdata     - write data
//   par_flip  - (DMEM_PARITY_EN) store the inverted parity bit
//   rdata     - combinational read data at addr
//   par_err   - (DMEM_PARITY_EN) stored parity disagrees with rdata
// Contents are not reset.
module dmem_array #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_PARITY_EN
    input  logic              par_flip,
    output logic              par_err,
`endif
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

`ifdef DMEM_PARITY_EN
    logic par_mem [DEPTH];

    // Even parity: stored bit makes the XOR of data and parity zero.
    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[addr] <= (^wdata) ^ par_flip;
        end
    end

    assign par_err = (^rdata) ^ par_mem[addr];
`endif

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the CPU load/store bus. Accepts one
// request per handshake, waits WAIT_CYCLES, performs the access once on the
// edge entering RESP, then holds the registered response until taken.
// Optional macro DMEM_PARITY_EN adds per-word parity and the par_inject port.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   req_valid/req_ready - request handshake
//   req_write           - 1 = store, 0 = load
//   req_addr, req_wdata - word address, store data
//   rsp_valid/rsp_ready - response handshake
//   rsp_rdata, rsp_err  - load data (0 for stores/errors), access error
//   busy                - high whenever not IDLE
//   par_inject          - (DMEM_PARITY_EN) store inverted parity on this store
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH_DEFAULT,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = DMEM_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
`ifdef DMEM_PARITY_EN
    input  logic              par_inject,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int              IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    dmem_state_t       state;
    logic [3:0]        cnt;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              do_access;
    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rdata_d;
    logic              err_d;

`ifdef DMEM_PARITY_EN
    logic inject_q;
    logic acc_inject;
    logic par_err;
`endif

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // With zero wait states the access happens on the accept edge, so the
    // access operands come straight from the request bus in that case.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
`ifdef DMEM_PARITY_EN
        acc_inject = inject_q;
`endif
        do_access = 1'b0;
        if (state == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
`ifdef DMEM_PARITY_EN
            acc_inject = par_inject;
`endif
            do_access = req_valid && (WAIT_CYCLES == 0);
        end else if (state == WAIT) begin
            do_access = (cnt == 4'd1);
        end
    end

    assign in_range = ({1'b0, acc_addr} < DEPTH_LIM);
    assign mem_we   = do_access && acc_write && in_range;

    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (!in_range) begin
            err_d = 1'b1;
        end else if (!acc_write) begin
            rdata_d = mem_rdata;
`ifdef DMEM_PARITY_EN
            if (par_err) begin
                err_d   = 1'b1;
                rdata_d = '0;
            end
`endif
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk      (clk),
        .we       (mem_we),
        .addr     (acc_addr[IDX_W-1:0]),
        .wdata    (acc_wdata),
`ifdef DMEM_PARITY_EN
        .par_flip (acc_inject),
        .par_err  (par_err),
`endif
        .rdata    (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifdef DMEM_PARITY_EN
            inject_q  <= 1'b0;
`endif
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
`ifdef DMEM_PARITY_EN
                        inject_q <= par_inject;
`endif
                        cnt      <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_rdata <= rdata_d;
                            rsp_err   <= err_d;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_rdata <= rdata_d;
                        rsp_err   <= err_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic on a
// WAIT_CYCLES=2 instance, and back-to-back traffic on a WAIT_CYCLES=0 one.
module tb_dmem_responder;

    localparam int W = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance with two wait states.
    logic       req_valid = 0, req_write = 0, rsp_ready = 0, par_inject = 0;
    logic [7:0] req_addr = 0, req_wdata = 0;
    logic       req_ready, rsp_valid, rsp_err, busy;
    logic [7:0] rsp_rdata;

    // Instance with zero wait states.
    logic       z_req_valid = 0, z_req_write = 0, z_rsp_ready = 1, z_par_inject = 0;
    logic [7:0] z_req_addr = 0, z_req_wdata = 0;
    logic       z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
    logic [7:0] z_rsp_rdata;

    dmem_responder #(.DEPTH(64), .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef DMEM_PARITY_EN
        .par_inject (par_inject),
`endif
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    dmem_responder #(.DEPTH(64), .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut_z (
        .clk        (clk),
        .reset      (reset),
`ifdef DMEM_PARITY_EN
        .par_inject (z_par_inject),
`endif
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_write  (z_req_write),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .rsp_valid  (z_rsp_valid),
        .rsp_ready  (z_rsp_ready),
        .rsp_rdata  (z_rsp_rdata),
        .rsp_err    (z_rsp_err),
        .busy       (z_busy)
    );

    int total = 0;
    int bad = 0;

    // Reference model of the WAIT_CYCLES=2 instance's storage.
    logic [7:0] ref_mem [64];
    bit         ref_known [64];
    bit         ref_bad [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance, starting in IDLE
    // at #1 after an edge. The response is held off for 'stall' cycles.
    task automatic txn(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                       input logic inj, input int stall);
        int lat;
        logic [7:0] exp_d;
        logic exp_e;
        logic [7:0] held_d;
        logic held_e;
        check("idle_ready", {31'd0, req_ready}, 1);
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd; par_inject = inj;
        tick();
        // Junk on the request bus must be ignored outside IDLE.
        req_valid = 1'($urandom); req_write = 1'($urandom);
        req_addr = 8'($urandom); req_wdata = 8'($urandom); par_inject = 1'($urandom);
        check("busy_wait", {31'd0, busy}, 1);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            check("ready_low_wait", {31'd0, req_ready}, 0);
            tick();
            lat++;
        end
        check("latency", lat, W);

        exp_d = 8'h00;
        exp_e = 1'b0;
        if (addr >= 8'd64) begin
            exp_e = 1'b1;
        end else if (wr) begin
            ref_mem[addr[5:0]] = wd;
            ref_known[addr[5:0]] = 1'b1;
`ifdef DMEM_PARITY_EN
            ref_bad[addr[5:0]] = inj;
`endif
        end else if (ref_bad[addr[5:0]]) begin
            exp_e = 1'b1;
        end else begin
            exp_d = ref_mem[addr[5:0]];
        end
        check("rdata", {24'd0, rsp_rdata}, {24'd0, exp_d});
        check("err", {31'd0, rsp_err}, {31'd0, exp_e});
        held_d = rsp_rdata;
        held_e = rsp_err;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", {31'd0, rsp_valid}, 1);
            check("stall_ready", {31'd0, req_ready}, 0);
            check("stall_rdata", {24'd0, rsp_rdata}, {24'd0, exp_d});
            check("stall_err", {31'd0, rsp_err}, {31'd0, exp_e});
        end
        req_valid = 0;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("post_valid", {31'd0, rsp_valid}, 0);
        check("post_idle", {31'd0, busy}, 0);
        if (held_d !== exp_d || held_e !== exp_e) begin
            check("held_once", 1, 0);
        end
    endtask

    // One request on the zero-wait instance with rsp_ready tied high.
    task automatic ztxn(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp_d, input logic exp_e);
        check("z_ready", {31'd0, z_req_ready}, 1);
        z_req_valid = 1; z_req_write = wr; z_req_addr = addr; z_req_wdata = wd;
        tick();
        check("z_valid", {31'd0, z_rsp_valid}, 1);
        check("z_ready_resp", {31'd0, z_req_ready}, 0);
        check("z_rdata", {24'd0, z_rsp_rdata}, {24'd0, exp_d});
        check("z_err", {31'd0, z_rsp_err}, {31'd0, exp_e});
        // Keep req_valid high: the next accept must wait for this edge anyway.
        z_req_addr = 8'($urandom); z_req_write = 1'($urandom);
        tick();
        check("z_valid_gap", {31'd0, z_rsp_valid}, 0);
    endtask

    initial begin
        logic       wr;
        logic [7:0] a;
        for (int i = 0; i < 64; i++) begin
            ref_known[i] = 1'b0;
            ref_bad[i] = 1'b0;
        end

        // Reset state.
        #2;
        check("rst_valid", {31'd0, rsp_valid}, 0);
        check("rst_ready", {31'd0, req_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rdata", {24'd0, rsp_rdata}, 0);
        check("rst_err", {31'd0, rsp_err}, 0);
        tick();
        tick();
        reset = 0;
        tick();

        // Store then load.
        txn(1, 8'h10, 8'hA5, 0, 0);
        txn(0, 8'h10, 8'h00, 0, 0);

        // Out of range, with mem[0] as a witness.
        txn(1, 8'h00, 8'h5A, 0, 0);
        txn(1, 8'h40, 8'h77, 0, 0);
        txn(0, 8'h40, 8'h00, 0, 0);
        txn(0, 8'h00, 8'h00, 0, 0);

        // Response backpressure.
        txn(0, 8'h10, 8'h00, 0, 5);

        // Reset while a store sits in WAIT.
        txn(1, 8'h05, 8'h11, 0, 0);
        req_valid = 1; req_write = 1; req_addr = 8'h05; req_wdata = 8'h3C;
        tick();
        req_valid = 0;
        check("mid_busy", {31'd0, busy}, 1);
        reset = 1;
        #1;
        check("mid_rst_valid", {31'd0, rsp_valid}, 0);
        check("mid_rst_ready", {31'd0, req_ready}, 1);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_rdata", {24'd0, rsp_rdata}, 0);
        check("mid_rst_err", {31'd0, rsp_err}, 0);
        tick();
        reset = 0;
        tick();
        txn(0, 8'h05, 8'h00, 0, 0);

`ifdef DMEM_PARITY_EN
        // Parity injection.
        txn(1, 8'h20, 8'h0F, 1, 0);
        txn(0, 8'h20, 8'h00, 0, 0);
        txn(1, 8'h20, 8'h0F, 0, 0);
        txn(0, 8'h20, 8'h00, 0, 0);
`endif

        // Random traffic; loads only of written or out-of-range addresses.
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255))
                                            : 8'($urandom_range(0, 63));
            wr = 1'($urandom);
            if (a < 8'd64 && !ref_known[a[5:0]]) wr = 1'b1;
            txn(wr, a, 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Zero wait states, back to back.
        for (int i = 0; i < 4; i++) begin
            ztxn(1, 8'(i), 8'(8'h30 + i), 8'h00, 0);
        end
        for (int i = 0; i < 4; i++) begin
            ztxn(0, 8'(i), 8'h00, 8'(8'h30 + i), 0);
        end
        ztxn(0, 8'hC0, 8'h00, 8'h00, 1);
        z_req_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
